stack_op_sequencer: RTL and testbench

STACK_OP_SEQUENCER -- requirements
Module: stack_op_sequencer

---
 rtl/stack_op_sequencer.sv | 105 ++++++++++
 tb/tb_stack_op_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// Microcode sequencer that turns NOP/PUSH/POP/ALU requests into stack strobes
// and ALU operand captures, tracking stack occupancy and flagging illegal requests.
module stack_op_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [15:0] op_imm,
    output logic        op_ready,
    output logic        done,
    output logic        err,
    output logic        stk_push,
    output logic        stk_pop,
    output logic        stk_sel,
    output logic [15:0] stk_din_uc,
    input  logic [15:0] stk_dout,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  depth
);

    typedef enum logic [2:0] {
        IDLE, PUSH_I, POP_1, POP_B, POP_A, LOAD_A, WB, DONE
    } state_t;

    state_t state, state_nxt;
    logic   err_q;
    logic   op_err;
    logic   accept;

    assign accept = op_valid && (state == IDLE);

    always_comb begin
        state_nxt = state;
        op_err    = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    state_nxt = DONE;
                    if (op_code[3]) begin
                        if (depth >= 5'd2) state_nxt = POP_B;
                        else               op_err    = 1'b1;
                    end else if (op_code == 4'b0001) begin
                        if (depth < 5'd16) state_nxt = PUSH_I;
                        else               op_err    = 1'b1;
                    end else if (op_code == 4'b0010) begin
                        if (depth != 5'd0) state_nxt = POP_1;
                        else               op_err    = 1'b1;
                    end else if (op_code != 4'b0000) begin
                        op_err = 1'b1;
                    end
                end
            end
            PUSH_I:  state_nxt = DONE;
            POP_1:   state_nxt = DONE;
            POP_B:   state_nxt = POP_A;
            POP_A:   state_nxt = LOAD_A;
            LOAD_A:  state_nxt = WB;
            WB:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        op_ready = (state == IDLE);
        stk_push = (state == PUSH_I) || (state == WB);
        stk_pop  = (state == POP_1) || (state == POP_B) || (state == POP_A);
        stk_sel  = (state == WB);
        done     = (state == DONE);
        err      = (state == DONE) && err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            depth      <= 5'd0;
            err_q      <= 1'b0;
            stk_din_uc <= 16'd0;
            alu_a      <= 16'd0;
            alu_b      <= 16'd0;
            alu_op     <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_op <= op_code;
                err_q  <= op_err;
            end
            if (accept && state_nxt == PUSH_I)
                stk_din_uc <= op_imm;
            if (stk_push)
                depth <= depth + 5'd1;
            else if (stk_pop)
                depth <= depth - 5'd1;
            // Stack read data lags the pop strobe by one cycle.
            if (state == POP_A)
                alu_b <= stk_dout;
            if (state == LOAD_A)
                alu_a <= stk_dout;
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: directed scenarios plus random ops against a
// queue-based stack model, with a small registered stack and adder as environment.
module tb_stack_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = 4'd0;
    logic [15:0] op_imm = 16'd0;
    logic        op_ready, done, err, stk_push, stk_pop, stk_sel;
    logic [15:0] stk_din_uc, stk_dout, alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  depth;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_stk[$];

    // Environment stack: registered read data, ALU result is a + b.
    logic [15:0] mem [16];
    logic [4:0]  sp;
    logic [15:0] alu_res;
    assign alu_res = alu_a + alu_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp       <= 5'd0;
            stk_dout <= 16'd0;
        end else if (stk_push) begin
            mem[sp[3:0]] <= stk_sel ? alu_res : stk_din_uc;
            sp           <= sp + 5'd1;
        end else if (stk_pop) begin
            stk_dout <= mem[sp[3:0] - 4'd1];
            sp       <= sp - 5'd1;
        end
    end

    stack_op_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_imm(op_imm),
        .op_ready(op_ready), .done(done), .err(err), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_sel(stk_sel), .stk_din_uc(stk_din_uc), .stk_dout(stk_dout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .depth(depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // kind: 0 NOP, 1 PUSH, 2 POP, 3 ALU, 4 error
    task automatic run_op(input logic [3:0] code, input logic [15:0] imm, input bit hold);
        int kind, lat, n;
        logic [15:0] a, b, popped;
        logic [5:0] exp_v;
        bit p, q;
        n = model_stk.size();
        if (code == 4'd0)                 kind = 0;
        else if (code == 4'd1)            kind = (n < 16) ? 1 : 4;
        else if (code == 4'd2)            kind = (n >= 1) ? 2 : 4;
        else if (code[3])                 kind = (n >= 2) ? 3 : 4;
        else                              kind = 4;
        lat = (kind == 3) ? 5 : ((kind == 1 || kind == 2) ? 2 : 1);

        for (int t = 0; t < 20 && !op_ready; t++) @(negedge clk);
        check("ready_wait", {31'd0, op_ready}, 32'd1);
        if (!op_ready) return;

        op_code  = code;
        op_imm   = imm;
        op_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (!hold) op_valid = 1'b0;
            p = (kind == 1 && c == 1) || (kind == 3 && c == 4);
            q = (kind == 2 && c == 1) || (kind == 3 && (c == 1 || c == 2));
            exp_v = {1'b0, p, q, (kind == 3 && c == 4), (c == lat), (kind == 4 && c == lat)};
            check($sformatf("ctl_c%0d_k%0d", c, kind),
                  {26'd0, op_ready, stk_push, stk_pop, stk_sel, done, err}, {26'd0, exp_v});
            if (kind == 1 && c == 1) check("din_uc", {16'd0, stk_din_uc}, {16'd0, imm});
        end
        op_valid = 1'b0;

        case (kind)
            1: model_stk.push_back(imm);
            2: begin
                popped = model_stk.pop_back();
                check("pop_data", {16'd0, stk_dout}, {16'd0, popped});
            end
            3: begin
                b = model_stk.pop_back();
                a = model_stk.pop_back();
                model_stk.push_back(a + b);
                check("alu_b", {16'd0, alu_b}, {16'd0, b});
                check("alu_a", {16'd0, alu_a}, {16'd0, a});
                check("alu_op", {28'd0, alu_op}, {28'd0, code});
            end
            default: ;
        endcase
        check("depth", {27'd0, depth}, model_stk.size());
    endtask

    initial begin
        logic [3:0] rc;
        int r;

        // Reset state
        #12;
        check("rst_vals", {depth, done, err, stk_push, stk_pop, stk_sel, alu_op},
              32'd0);
        check("rst_data", {stk_din_uc, alu_a}, 32'd0);
        check("rst_alub", {16'd0, alu_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, op_ready}, 32'd1);

        // Two pushes then an ALU op on [5,3]
        run_op(4'b0001, 16'h0005, 1'b0);
        run_op(4'b0001, 16'h0003, 1'b0);
        run_op(4'b1000, 16'h0000, 1'b0);
        run_op(4'b0010, 16'h0000, 1'b0);

        // Pop on empty, NOP
        run_op(4'b0010, 16'h0000, 1'b0);
        run_op(4'b0000, 16'h1234, 1'b0);

        // Fill to 16, then overflow push
        for (int i = 0; i < 16; i++) run_op(4'b0001, 16'(i * 7 + 1), 1'b0);
        run_op(4'b0001, 16'hBEEF, 1'b0);
        check("din_hold_after_err", {16'd0, stk_din_uc}, {16'd0, model_stk[15]});

        // Illegal code with op_valid held through DONE
        run_op(4'b0101, 16'h0000, 1'b1);
        @(negedge clk);
        check("no_reaccept", {30'd0, done, stk_pop}, 32'd0);
        check("ready_idle", {31'd0, op_ready}, 32'd1);

        // Reset during POP_A of an ALU op
        op_code  = 4'b1001;
        op_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("in_pop_a", {30'd0, stk_pop, stk_push}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rst_strobes", {29'd0, stk_push, stk_pop, stk_sel}, 32'd0);
        check("rst_depth", {27'd0, depth}, 32'd0);
        model_stk.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst", {30'd0, done, op_ready}, 32'd1);
        end

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      rc = 4'b0000;
            else if (r <= 3) rc = 4'b0001;
            else if (r <= 5) rc = 4'b0010;
            else if (r <= 8) rc = 4'(8 + $urandom_range(0, 7));
            else             rc = 4'($urandom_range(3, 7));
            run_op(rc, 16'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
